// File: rtl/lcg_stream_checker.sv
// Receive-side checker for the fuzz-harness LCG stream: regenerates the
// expected sequence from a loaded seed and counts frames and miscompares.
module lcg_stream_checker #(
  parameter int NWORDS      = 9,
  parameter int LAST_BITS   = 9,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      seed_load,
  input  logic [31:0]               seed_in,
  input  logic                      in_valid,
  input  logic [31:0]               in_data,
  output logic                      in_ready,
  output logic                      mismatch,
  output logic [$clog2(NWORDS)-1:0] word_idx,
  output logic [CNT_W-1:0]          frame_count,
  output logic [CNT_W-1:0]          err_count,
  output logic                      first_err_valid,
  output logic [CNT_W-1:0]          first_err_frame,
  output logic [$clog2(NWORDS)-1:0] first_err_word,
  output logic                      halted
);

  localparam int          IDX_W     = $clog2(NWORDS);
  localparam logic [31:0] LCG_MUL   = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC   = 32'h0000_3039;
  localparam logic [31:0] LAST_MASK = (LAST_BITS >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << LAST_BITS) - 32'd1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t            state_q;
  logic [31:0]       lcg_q;
  logic [31:0]       lcg_d;
  logic [31:0]       word_mask;
  logic              accept;
  logic              miscompare;
  logic              in_ready_q;
  logic              mismatch_q;
  logic              halted_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [CNT_W-1:0]  frame_count_q;
  logic [CNT_W-1:0]  err_count_q;
  logic              first_err_valid_q;
  logic [CNT_W-1:0]  first_err_frame_q;
  logic [IDX_W-1:0]  first_err_word_q;

  // Expected word, per-position compare mask and handshake qualification.
  always_comb begin
    lcg_d = lcg_q * LCG_MUL + LCG_INC;
    if (word_idx_q == LAST_IDX) begin
      word_mask = LAST_MASK;
    end else begin
      word_mask = 32'hFFFF_FFFF;
    end
    accept     = in_valid && in_ready_q && !seed_load;
    miscompare = ((in_data ^ lcg_d) & word_mask) != 32'd0;
  end

  // Control FSM, sequence register, counters and first-error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      lcg_q             <= 32'd0;
      in_ready_q        <= 1'b0;
      mismatch_q        <= 1'b0;
      halted_q          <= 1'b0;
      word_idx_q        <= '0;
      frame_count_q     <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_frame_q <= '0;
      first_err_word_q  <= '0;
    end else if (seed_load) begin
      // A seed load overrides any word offered in the same cycle.
      state_q           <= RUN;
      lcg_q             <= seed_in;
      in_ready_q        <= 1'b1;
      mismatch_q        <= 1'b0;
      halted_q          <= 1'b0;
      word_idx_q        <= '0;
      frame_count_q     <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_frame_q <= '0;
      first_err_word_q  <= '0;
    end else begin
      mismatch_q <= accept && miscompare;
      if (accept) begin
        lcg_q <= lcg_d;
        if (word_idx_q == LAST_IDX) begin
          word_idx_q <= '0;
          if (frame_count_q != {CNT_W{1'b1}}) begin
            frame_count_q <= frame_count_q + CNT_W'(1);
          end
        end else begin
          word_idx_q <= word_idx_q + IDX_W'(1);
        end
        if (miscompare) begin
          if (err_count_q != {CNT_W{1'b1}}) begin
            err_count_q <= err_count_q + CNT_W'(1);
          end
          if (!first_err_valid_q) begin
            first_err_valid_q <= 1'b1;
            first_err_frame_q <= frame_count_q;
            first_err_word_q  <= word_idx_q;
          end
        end
      end
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b0;
          halted_q   <= 1'b0;
        end
        RUN: begin
          if (accept && miscompare && (STOP_ON_ERR != 0)) begin
            state_q    <= HALT;
            in_ready_q <= 1'b0;
            halted_q   <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        HALT: begin
          in_ready_q <= 1'b0;
          halted_q   <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign mismatch        = mismatch_q;
  assign word_idx        = word_idx_q;
  assign frame_count     = frame_count_q;
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_frame = first_err_frame_q;
  assign first_err_word  = first_err_word_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_lcg_stream_checker.sv
// Bench for lcg_stream_checker: three configurations driven in lockstep and
// checked against an arithmetic reference model plus directed vectors.
module tb_lcg_stream_checker;

  localparam int NWORDS    = 9;
  localparam int LAST_BITS = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        sl_i;
  logic [31:0] seed_i;
  logic        v_i;
  logic [31:0] data_i;

  logic        rdy0, rdy1, rdy2, mis0, mis1, mis2, fev0, fev1, fev2, hlt0, hlt1, hlt2;
  logic [3:0]  idx0, idx1, idx2, few0, few1, few2;
  logic [15:0] fc0, fc1, ec0, ec1, fef0, fef1;
  logic [2:0]  fc2, ec2, fef2;

  int tests = 0;
  int fails = 0;

  longint unsigned m_lcg [3];
  int m_st [3], m_idx [3], m_fr [3], m_er [3], m_fev [3], m_fef [3], m_few [3], m_mis [3];
  int cfg_stop [3] = '{0, 1, 0};
  int cfg_max  [3] = '{65535, 65535, 7};

  typedef struct {
    logic        sl;
    logic [31:0] seed;
    logic        v;
    logic [31:0] data;
    int          mis;
    int          idx;
    int          err;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  lcg_stream_checker dut0 (
    .clk(clk), .rst(rst), .seed_load(sl_i), .seed_in(seed_i), .in_valid(v_i), .in_data(data_i),
    .in_ready(rdy0), .mismatch(mis0), .word_idx(idx0), .frame_count(fc0), .err_count(ec0),
    .first_err_valid(fev0), .first_err_frame(fef0), .first_err_word(few0), .halted(hlt0));

  lcg_stream_checker #(.STOP_ON_ERR(1)) dut1 (
    .clk(clk), .rst(rst), .seed_load(sl_i), .seed_in(seed_i), .in_valid(v_i), .in_data(data_i),
    .in_ready(rdy1), .mismatch(mis1), .word_idx(idx1), .frame_count(fc1), .err_count(ec1),
    .first_err_valid(fev1), .first_err_frame(fef1), .first_err_word(few1), .halted(hlt1));

  lcg_stream_checker #(.CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .seed_load(sl_i), .seed_in(seed_i), .in_valid(v_i), .in_data(data_i),
    .in_ready(rdy2), .mismatch(mis2), .word_idx(idx2), .frame_count(fc2), .err_count(ec2),
    .first_err_valid(fev2), .first_err_frame(fef2), .first_err_word(few2), .halted(hlt2));

  function automatic longint unsigned nxt(longint unsigned s);
    return (s * 64'd1103515245 + 64'd12345) % 64'd4294967296;
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_lcg[k] = 0; m_st[k] = 0; m_idx[k] = 0; m_fr[k] = 0; m_er[k] = 0;
      m_fev[k] = 0; m_fef[k] = 0; m_few[k] = 0; m_mis[k] = 0;
    end
  endtask

  // One rising edge of the reference model for configuration k (0 idle, 1 run, 2 halt).
  task automatic model_edge(int k);
    longint unsigned e;
    longint unsigned diff;
    m_mis[k] = 0;
    if (sl_i) begin
      m_lcg[k] = {32'd0, seed_i};
      m_idx[k] = 0; m_fr[k] = 0; m_er[k] = 0; m_fev[k] = 0; m_fef[k] = 0; m_few[k] = 0;
      m_st[k] = 1;
    end else if (m_st[k] == 1 && v_i) begin
      e    = nxt(m_lcg[k]);
      diff = {32'd0, data_i} ^ e;
      if (m_idx[k] == NWORDS - 1) diff = diff % (64'd1 << LAST_BITS);
      m_lcg[k] = e;
      if (diff != 0) begin
        m_mis[k] = 1;
        if (m_fev[k] == 0) begin
          m_fev[k] = 1; m_fef[k] = m_fr[k]; m_few[k] = m_idx[k];
        end
        if (m_er[k] < cfg_max[k]) m_er[k]++;
        if (cfg_stop[k] != 0) m_st[k] = 2;
      end
      m_idx[k]++;
      if (m_idx[k] == NWORDS) begin
        m_idx[k] = 0;
        if (m_fr[k] < cfg_max[k]) m_fr[k]++;
      end
    end
  endtask

  task automatic check_dut(int k, string tag);
    int a [9];
    case (k)
      0: a = '{int'(rdy0), int'(mis0), int'(idx0), int'(fc0), int'(ec0), int'(fev0), int'(fef0), int'(few0), int'(hlt0)};
      1: a = '{int'(rdy1), int'(mis1), int'(idx1), int'(fc1), int'(ec1), int'(fev1), int'(fef1), int'(few1), int'(hlt1)};
      default: a = '{int'(rdy2), int'(mis2), int'(idx2), int'(fc2), int'(ec2), int'(fev2), int'(fef2), int'(few2), int'(hlt2)};
    endcase
    chk($sformatf("%s dut%0d in_ready", tag, k), a[0], int'(m_st[k] == 1));
    chk($sformatf("%s dut%0d mismatch", tag, k), a[1], m_mis[k]);
    chk($sformatf("%s dut%0d word_idx", tag, k), a[2], m_idx[k]);
    chk($sformatf("%s dut%0d frame_count", tag, k), a[3], m_fr[k]);
    chk($sformatf("%s dut%0d err_count", tag, k), a[4], m_er[k]);
    chk($sformatf("%s dut%0d first_err_valid", tag, k), a[5], m_fev[k]);
    chk($sformatf("%s dut%0d first_err_frame", tag, k), a[6], m_fef[k]);
    chk($sformatf("%s dut%0d first_err_word", tag, k), a[7], m_few[k]);
    chk($sformatf("%s dut%0d halted", tag, k), a[8], int'(m_st[k] == 2));
  endtask

  task automatic setin(logic sl, logic [31:0] seed, logic v, logic [31:0] data);
    sl_i = sl; seed_i = seed; v_i = v; data_i = data;
  endtask

  task automatic step(string tag);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k);
    #1;
    for (int k = 0; k < 3; k++) check_dut(k, tag);
  endtask

  // Next word dut0 expects, optionally corrupted by xor.
  function automatic logic [31:0] good(logic [31:0] flip);
    longint unsigned e;
    e = nxt(m_lcg[0]);
    return e[31:0] ^ flip;
  endfunction

  initial begin
    rst = 1'b1;
    setin(1'b0, 32'd0, 1'b0, 32'd0);
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) check_dut(k, "reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    step("idle");

    tbl[0] = '{1'b1, 32'd0, 1'b0, 32'h0000_0000, 0, 0, 0};
    tbl[1] = '{1'b0, 32'd0, 1'b1, 32'h0000_3039, 0, 1, 0};
    tbl[2] = '{1'b0, 32'd0, 1'b1, 32'hD3DC_167E, 0, 2, 0};
    tbl[3] = '{1'b1, 32'd0, 1'b0, 32'h0000_0000, 0, 0, 0};
    tbl[4] = '{1'b0, 32'd0, 1'b1, 32'h0000_3038, 1, 1, 1};
    tbl[5] = '{1'b0, 32'd0, 1'b1, 32'hD3DC_167E, 0, 2, 1};
    tbl[6] = '{1'b1, 32'd0, 1'b1, 32'hDEAD_BEEF, 0, 0, 0};
    tbl[7] = '{1'b0, 32'd0, 1'b1, 32'h0000_3039, 0, 1, 0};
    tbl[8] = '{1'b0, 32'd0, 1'b0, 32'h0000_3039, 0, 1, 0};
    for (int i = 0; i < 9; i++) begin
      setin(tbl[i].sl, tbl[i].seed, tbl[i].v, tbl[i].data);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d mismatch", i), int'(mis0), tbl[i].mis);
      chk($sformatf("vec%0d word_idx", i), int'(idx0), tbl[i].idx);
      chk($sformatf("vec%0d err_count", i), int'(ec0), tbl[i].err);
      if (i == 4) begin
        chk("vec4 first_err_valid", int'(fev0), 1);
        chk("vec4 first_err_frame", int'(fef0), 0);
        chk("vec4 first_err_word", int'(few0), 0);
      end
    end

    // Full frame; the upper 23 bits of the final word are ignored.
    setin(1'b1, $urandom, 1'b0, 32'd0);
    step("frame seed");
    for (int w = 0; w < NWORDS; w++) begin
      setin(1'b0, 32'd0, 1'b1, good(w == NWORDS - 1 ? ($urandom | 32'h200) & 32'hFFFF_FE00 : 32'd0));
      step("frame");
      chk("frame mismatch", int'(mis0), 0);
    end
    chk("frame frame_count", int'(fc0), 1);
    chk("frame word_idx", int'(idx0), 0);

    // Halt-on-error configuration: bad word at index 3.
    setin(1'b1, $urandom, 1'b0, 32'd0);
    step("stop seed");
    for (int w = 0; w < 4; w++) begin
      setin(1'b0, 32'd0, 1'b1, good(w == 3 ? 32'h0000_0100 : 32'd0));
      step("stop");
    end
    chk("stop halted", int'(hlt1), 1);
    chk("stop in_ready", int'(rdy1), 0);
    chk("stop first_err_word", int'(few1), 3);
    setin(1'b0, 32'd0, 1'b1, 32'd0);
    step("stop held");
    chk("stop held word_idx", int'(idx1), 4);
    setin(1'b1, $urandom, 1'b0, 32'd0);
    step("stop reseed");
    chk("stop reseed halted", int'(hlt1), 0);
    chk("stop reseed in_ready", int'(rdy1), 1);
    chk("stop reseed err_count", int'(ec1), 0);
    chk("stop reseed first_err_valid", int'(fev1), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      int r;
      logic [31:0] flip;
      r = $urandom_range(0, 99);
      if (r < 70)      flip = 32'd0;
      else if (r < 85) flip = $urandom & 32'hFFFF_FE00;
      else             flip = $urandom | 32'd1;
      setin($urandom_range(0, 39) == 0, $urandom, $urandom_range(0, 3) != 0, good(flip));
      step("rand");
    end

    // Counter saturation on the narrow-counter configuration.
    setin(1'b1, $urandom, 1'b0, 32'd0);
    step("sat seed");
    for (int w = 0; w < 8 * NWORDS; w++) begin
      setin(1'b0, 32'd0, 1'b1, good(32'd0));
      step("sat frames");
    end
    chk("sat frame_count narrow", int'(fc2), 7);
    chk("sat frame_count wide", int'(fc0), 8);
    for (int w = 0; w < 9; w++) begin
      setin(1'b0, 32'd0, 1'b1, good(32'h0000_0001));
      step("sat errs");
    end
    chk("sat err_count narrow", int'(ec2), 7);
    chk("sat err_count wide", int'(ec0), 9);
    chk("sat mismatch continues", int'(mis2), 1);

    // Asynchronous reset mid-frame.
    setin(1'b1, $urandom, 1'b0, 32'd0);
    step("rst seed");
    for (int w = 0; w < 5; w++) begin
      setin(1'b0, 32'd0, 1'b1, good((w == 1 || w == 3) ? 32'h8000_0000 : 32'd0));
      step("rst pre");
    end
    chk("rst pre word_idx", int'(idx0), 5);
    chk("rst pre err_count", int'(ec0), 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) check_dut(k, "rst async");
    chk("rst async word_idx", int'(idx0), 0);
    chk("rst async err_count", int'(ec0), 0);
    chk("rst async in_ready", int'(rdy0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int w = 0; w < 3; w++) begin
      setin(1'b0, 32'd0, 1'b1, $urandom);
      step("rst idle");
      chk("rst idle in_ready", int'(rdy0), 0);
      chk("rst idle word_idx", int'(idx0), 0);
    end
    setin(1'b1, 32'd0, 1'b0, 32'd0);
    step("rst reseed");
    chk("rst reseed in_ready", int'(rdy0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
